// File: rtl/cfu_requant.sv
// cfu_requant: output-side CFU responder for the int8 convolution path.
// Requantizes int32 accumulators to int8 using bias, a Q31 fixed-point multiplier,
// a right shift, an output offset and an activation clamp. Four results are packed
// into one 32-bit word. One command is outstanding at a time.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_payload_function_id[2:0]  funct3 opcode: 0 SET_MULT, 1 SET_OFS, 2 PUSH,
//                                 3 READ_PACK, 4 CLEAR, 5-7 no-op
//   cmd_payload_inputs_0/1        operands, latched at the handshake
//   rsp_valid / rsp_ready         response handshake
//   rsp_payload_outputs_0         registered response word
//
// Build option: define CFU_REQUANT_ROUND_EN for round-half-up in both the Q31 high
// multiply and the right shift; without it both steps truncate toward -inf.
module cfu_requant (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  typedef enum logic [2:0] {StIdle, StMul, StShift, StClamp, StResp} state_e;

  state_e             state_q, state_d;
  logic signed [31:0] mult_q, mult_d;
  logic [4:0]         shift_q, shift_d;
  logic signed [31:0] ofs_q, ofs_d;
  logic signed [7:0]  amin_q, amin_d;
  logic signed [7:0]  amax_q, amax_d;
  logic [31:0]        pack_q, pack_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        rsp_q, rsp_d;
  // PUSH pipeline stage registers
  logic [31:0]        x_q, x_d;
  logic               sat_q, sat_d;
  logic signed [63:0] p_q, p_d;
  logic signed [32:0] s_q, s_d;

  logic signed [63:0] x_ext, mult_ext, prod, p_rnd;
  logic signed [32:0] nudge, h_ext, s_sum, s_val;
  logic [31:0]        h;
  logic signed [33:0] o, amin_ext, amax_ext, c;
  logic [31:0]        pack_ins;

  // MUL stage: full 64-bit signed product
  assign x_ext    = {{32{x_q[31]}}, x_q};
  assign mult_ext = {{32{mult_q[31]}}, mult_q};
  assign prod     = x_ext * mult_ext;

  // SHIFT stage: Q31 high half, then right shift
`ifdef CFU_REQUANT_ROUND_EN
  assign p_rnd = p_q + 64'sd1073741824;
  assign nudge = (shift_q != 5'd0) ? (33'sd1 <<< (shift_q - 5'd1)) : 33'sd0;
`else
  assign p_rnd = p_q;
  assign nudge = 33'sd0;
`endif
  // INT_MIN * INT_MIN is the only product whose Q31 high half overflows s32
  assign h     = sat_q ? 32'h7FFF_FFFF : p_rnd[62:31];
  assign h_ext = {h[31], h};
  assign s_sum = h_ext + nudge;
  assign s_val = s_sum >>> shift_q;

  // CLAMP stage: offset, then min bound, then max bound (max wins if bounds cross)
  assign o        = {s_q[32], s_q} + {{2{ofs_q[31]}}, ofs_q};
  assign amin_ext = {{26{amin_q[7]}}, amin_q};
  assign amax_ext = {{26{amax_q[7]}}, amax_q};

  always_comb begin
    c = o;
    if (c < amin_ext) c = amin_ext;
    if (c > amax_ext) c = amax_ext;
    pack_ins = pack_q;
    pack_ins[8*lane_q +: 8] = c[7:0];
  end

  logic unused_bits;
  assign unused_bits = ^{cmd_payload_function_id[9:3], p_rnd[63], p_rnd[30:0], c[33:8]};

  always_comb begin
    state_d   = state_q;
    mult_d    = mult_q;
    shift_d   = shift_q;
    ofs_d     = ofs_q;
    amin_d    = amin_q;
    amax_d    = amax_q;
    pack_d    = pack_q;
    lane_d    = lane_q;
    rsp_d     = rsp_q;
    x_d       = x_q;
    sat_d     = sat_q;
    p_d       = p_q;
    s_d       = s_q;
    cmd_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StResp;
          rsp_d   = '0;
          case (cmd_payload_function_id[2:0])
            3'd0: begin
              mult_d  = cmd_payload_inputs_0;
              shift_d = cmd_payload_inputs_1[4:0];
            end
            3'd1: begin
              ofs_d  = cmd_payload_inputs_0;
              amin_d = cmd_payload_inputs_1[7:0];
              amax_d = cmd_payload_inputs_1[15:8];
            end
            3'd2: begin
              x_d     = cmd_payload_inputs_0 + cmd_payload_inputs_1;
              state_d = StMul;
            end
            3'd3: begin
              rsp_d  = pack_q;
              pack_d = '0;
              lane_d = '0;
            end
            3'd4: begin
              pack_d = '0;
              lane_d = '0;
            end
            default: ;
          endcase
        end
      end
      StMul: begin
        p_d     = prod;
        sat_d   = (x_q == 32'h8000_0000) && (mult_q == 32'sh8000_0000);
        state_d = StShift;
      end
      StShift: begin
        s_d     = s_val;
        state_d = StClamp;
      end
      StClamp: begin
        pack_d  = pack_ins;
        lane_d  = lane_q + 2'd1;
        rsp_d   = pack_ins;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_q  <= '0;
      shift_q <= '0;
      ofs_q   <= '0;
      amin_q  <= 8'sh80;
      amax_q  <= 8'sh7F;
      pack_q  <= '0;
      lane_q  <= '0;
      rsp_q   <= '0;
      x_q     <= '0;
      sat_q   <= 1'b0;
      p_q     <= '0;
      s_q     <= '0;
    end else begin
      mult_q  <= mult_d;
      shift_q <= shift_d;
      ofs_q   <= ofs_d;
      amin_q  <= amin_d;
      amax_q  <= amax_d;
      pack_q  <= pack_d;
      lane_q  <= lane_d;
      rsp_q   <= rsp_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

  assign rsp_payload_outputs_0 = rsp_q;

endmodule

// File: tb/tb_cfu_requant.sv
// Self-checking bench for cfu_requant: directed commands, a behavioural model that
// predicts every response word, and a compare process that checks the response on
// every cycle rsp_valid is high.
module tb_cfu_requant;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_out;

  always #5 clk = ~clk;

  cfu_requant dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  int last_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mult;
  int          m_shift;
  int          m_ofs;
  int          m_amin;
  int          m_amax;
  logic [31:0] m_pack;
  int          m_lane;
  logic [31:0] exp_q[$];

  function automatic logic [7:0] requant(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] mult, input int shift,
                                         input int ofs, input int amin, input int amax);
    logic [31:0] xs;
    int          xi;
    int          mi;
    int          hi;
    longint      p;
    longint      s;
    longint      o;
    xs = a + b;
    xi = xs;
    mi = mult;
    if (xs == 32'h8000_0000 && mult == 32'h8000_0000) begin
      hi = 2147483647;
    end else begin
      p = longint'(xi) * longint'(mi);
`ifdef CFU_REQUANT_ROUND_EN
      p = p + (longint'(1) << 30);
`endif
      hi = int'(p >>> 31);
    end
    s = longint'(hi);
`ifdef CFU_REQUANT_ROUND_EN
    if (shift > 0) s = s + (longint'(1) << (shift - 1));
`endif
    s = s >>> shift;
    o = s + longint'(ofs);
    if (o < longint'(amin)) o = amin;
    if (o > longint'(amax)) o = amax;
    return o[7:0];
  endfunction

  task automatic model_reset();
    m_mult  = '0;
    m_shift = 0;
    m_ofs   = 0;
    m_amin  = -128;
    m_amax  = 127;
    m_pack  = '0;
    m_lane  = 0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [7:0] v;
    case (f)
      3'd0: begin m_mult = a; m_shift = int'(b[4:0]); exp_q.push_back(32'h0); end
      3'd1: begin
        m_ofs  = a;
        m_amin = int'($signed(b[7:0]));
        m_amax = int'($signed(b[15:8]));
        exp_q.push_back(32'h0);
      end
      3'd2: begin
        v = requant(a, b, m_mult, m_shift, m_ofs, m_amin, m_amax);
        m_pack[8*m_lane +: 8] = v;
        m_lane = (m_lane + 1) % 4;
        exp_q.push_back(m_pack);
      end
      3'd3: begin exp_q.push_back(m_pack); m_pack = '0; m_lane = 0; end
      3'd4: begin m_pack = '0; m_lane = 0; exp_q.push_back(32'h0); end
      default: exp_q.push_back(32'h0);
    endcase
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      else check("rsp_payload", rsp_out, exp_q[0]);
    end
  end

  always @(posedge clk) begin
    if (reset_n && rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // ---------------- driver ----------------
  // hold > 0: keep rsp_ready low that many cycles while offering a READ_PACK, which
  // stays offered after the response handshake.
  task automatic send(input string name, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input int hold, input bit lit_en,
                      input logic [31:0] lit);
    int          lat;
    logic [31:0] got;
    @(negedge clk);
    fid = {7'h5A, f};
    in0 = a;
    in1 = b;
    cmd_valid = 1'b1;
    lat = 0;
    while (!cmd_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    last_wait = lat;
    if (!cmd_ready) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_apply(f, a, b);
    #1;
    cmd_valid = 1'b0;
    in0 = $urandom;
    in1 = $urandom;
    fid = 10'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    check({name, " latency"}, lat, (f == 3'd2) ? 32'd4 : 32'd1);
    if (hold > 0) begin
      fid = {7'h00, 3'd3};
      cmd_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      check({name, " hold cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
      check({name, " hold rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    got = rsp_out;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (lit_en) check({name, " value"}, got, lit);
  endtask

  logic [31:0] lit_intmin;
  logic [31:0] lit_rnd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
`ifdef CFU_REQUANT_ROUND_EN
    lit_intmin = 32'h0000_0001;
    lit_rnd    = 32'h0000_0001;
`else
    lit_intmin = 32'h0000_0000;
    lit_rnd    = 32'h0000_0000;
`endif

    // Pin the model with hand-computed values
    check("model 400>>1", {24'd0, requant(32'd400, 32'd0, 32'h4000_0000, 1, 0, -128, 127)},
          32'h64);
    check("model -4>>1", {24'd0, requant(-32'sd4, 32'd0, 32'h4000_0000, 1, 0, -128, 127)},
          32'hFF);
    check("model ofs", {24'd0, requant(32'd60, 32'd40, 32'h4000_0000, 0, -128, -128, 127)},
          32'hB2);
    check("model crossed", {24'd0, requant(32'd0, 32'd0, 32'h4000_0000, 0, 0, 20, 10)},
          32'h0A);

    // Reset state
    repeat (3) @(negedge clk);
    check("in reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post reset payload", rsp_out, 32'd0);

    send("rp0", 3'd3, 32'd0, 32'd0, 0, 1'b1, 32'h0);

    // Pack four lanes with shift 1
    send("set_mult", 3'd0, 32'h4000_0000, 32'd1, 0, 1'b1, 32'h0);
    send("set_ofs", 3'd1, 32'd0, 32'h7F80, 0, 1'b1, 32'h0);
    send("push400", 3'd2, 32'd400, 32'd0, 0, 1'b1, 32'h0000_0064);
    send("push1000", 3'd2, 32'd1000, 32'd0, 0, 1'b1, 32'h0000_7F64);
    send("push-1000", 3'd2, -32'sd1000, 32'd0, 0, 1'b1, 32'h0080_7F64);
    send("push-4", 3'd2, -32'sd4, 32'd0, 0, 1'b1, 32'hFF80_7F64);
    send("read_pack", 3'd3, 32'd0, 32'd0, 0, 1'b1, 32'hFF80_7F64);
    send("read_cleared", 3'd3, 32'd0, 32'd0, 0, 1'b1, 32'h0);
    send("push_lane0", 3'd2, 32'd400, 32'd0, 0, 1'b1, 32'h0000_0064);

    // Negative output offset, shift 0
    send("set_mult0", 3'd0, 32'h4000_0000, 32'd0, 0, 1'b1, 32'h0);
    send("set_ofs-128", 3'd1, 32'hFFFF_FF80, 32'h7F80, 0, 1'b1, 32'h0);
    send("clear", 3'd4, 32'd0, 32'd0, 0, 1'b1, 32'h0);
    send("push60+40", 3'd2, 32'd60, 32'd40, 0, 1'b1, 32'h0000_00B2);

    // Stalled response with a command waiting behind it
    send("push_hold", 3'd2, 32'd20, 32'd0, 5, 1'b1, 32'h0000_8AB2);
    send("read_after_hold", 3'd3, 32'd0, 32'd0, 0, 1'b1, 32'h0000_8AB2);
    check("read_after_hold accepted at once", last_wait, 32'd0);

    // Reserved opcodes
    send("op5", 3'd5, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1, 32'h0);
    send("op7", 3'd7, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1, 32'h0);

    // Crossed bounds: max applied last
    send("set_ofs_cross", 3'd1, 32'd0, 32'h0A14, 0, 1'b1, 32'h0);
    send("push_cross", 3'd2, 32'd0, 32'd0, 0, 1'b1, 32'h0000_000A);

    // Rounding nudge in the shift
    send("set_ofs_full", 3'd1, 32'd0, 32'h7F80, 0, 1'b1, 32'h0);
    send("set_mult_sh2", 3'd0, 32'h4000_0000, 32'd2, 0, 1'b1, 32'h0);
    send("clear2", 3'd4, 32'd0, 32'd0, 0, 1'b1, 32'h0);
    send("push6_sh2", 3'd2, 32'd6, 32'd0, 0, 1'b1, lit_rnd);
    send("push-6_sh2", 3'd2, -32'sd6, 32'd0, 0, 1'b0, 32'h0);

    // INT_MIN * INT_MIN saturation
    send("set_mult_min", 3'd0, 32'h8000_0000, 32'd31, 0, 1'b1, 32'h0);
    send("clear3", 3'd4, 32'd0, 32'd0, 0, 1'b1, 32'h0);
    send("push_intmin", 3'd2, 32'h8000_0000, 32'd0, 0, 1'b1, lit_intmin);
    send("push_mix", 3'd2, 32'h7FFF_FFFF, 32'h0000_1234, 0, 1'b0, 32'h0);

    // Asynchronous reset while a PUSH sits in MUL
    @(negedge clk);
    fid = {7'h00, 3'd2};
    in0 = 32'd100;
    in1 = 32'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    model_apply(3'd2, 32'd100, 32'd0);
    #1;
    cmd_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid reset payload", rsp_out, 32'd0);
    check("mid reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("after reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    send("rp_after_reset", 3'd3, 32'd0, 32'd0, 0, 1'b1, 32'h0);
    send("set_mult_r", 3'd0, 32'h4000_0000, 32'd0, 0, 1'b1, 32'h0);
    send("push_max_default", 3'd2, 32'd1000, 32'd0, 0, 1'b1, 32'h0000_007F);
    send("push_min_default", 3'd2, -32'sd1000, 32'd0, 0, 1'b1, 32'h0000_807F);
    check("queue drained", exp_q.size(), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
